// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative RV32M multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_e;

  function automatic int iter_count(input int width, input int k);
    return width / k;
  endfunction

  // A single-iteration configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int width, input int k);
    return (width / k > 1) ? $clog2(width / k) : 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: hi + mcand * (K low multiplier bits), WIDTH+K bits wide.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [K-1:0]       bits,
  output logic [WIDTH+K-1:0] sum
);

  // hi + mcand*(2^K-1) < 2^(WIDTH+K), so the sum never overflows.
  always_comb begin
    sum = (WIDTH+K)'(hi) + (WIDTH+K)'(mcand) * (WIDTH+K)'(bits);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU unit: magnitude shift-add, sign fix-up at the end.
module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  mul_op_e          op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = iter_count(WIDTH, K);
  localparam int CW = cnt_width(WIDTH, K);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  mul_state_e       state;
  mul_op_e          op_q;
  logic [WIDTH-1:0] mcand, hi, lo, result;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic               accept, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+K-1:0] sum;
  logic [2*WIDTH-1:0] prod_next, prod_fix;

  always_comb begin
    in_ready_o = (state == IDLE) || (state == DONE && out_ready_i);
    accept     = in_valid_i && in_ready_o && !flush_i;
    a_neg      = (op_i == MULH || op_i == MULHSU) && operand_a_i[WIDTH-1];
    b_neg      = (op_i == MULH) && operand_b_i[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    a_mag      = a_neg ? -operand_a_i : operand_a_i;
    b_mag      = b_neg ? -operand_b_i : operand_b_i;
  end

  mul_step #(.WIDTH(WIDTH), .K(K)) u_step (
    .hi   (hi),
    .mcand(mcand),
    .bits (lo[K-1:0]),
    .sum  (sum)
  );

  always_comb begin
    prod_next = (2*WIDTH)'({sum, lo} >> K);
    prod_fix  = neg ? -{hi, lo} : {hi, lo};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      op_q   <= MUL;
      mcand  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else if (accept) begin
      // Covers both IDLE and the DONE hand-off, so back-to-back ops skip IDLE.
      op_q  <= op_i;
      mcand <= a_mag;
      neg   <= a_neg ^ b_neg;
      hi    <= '0;
      lo    <= b_mag;
      cnt   <= CNT_INIT;
      state <= CALC;
    end else begin
      case (state)
        CALC: begin
          hi <= prod_next[2*WIDTH-1:WIDTH];
          lo <= prod_next[WIDTH-1:0];
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          result <= (op_q == MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
          state  <= DONE;
        end
        DONE: if (out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid_o = (state == DONE);
  assign result_o    = result;

endmodule

// File: tb/tb_mul_iter.sv
// Directed checks of mul_iter at K=1 and K=4, plus a K=4 sweep against a 64-bit model.
module tb_mul_iter;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  flush, in_valid, out_ready, in_ready, out_valid;
  mul_op_e     op  [2];
  logic [31:0] a   [2];
  logic [31:0] b   [2];
  logic [31:0] res [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_k1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .op_i(op[0]), .operand_a_i(a[0]), .operand_b_i(b[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .result_o(res[0])
  );

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_k4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .op_i(op[1]), .operand_a_i(a[1]), .operand_b_i(b[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .result_o(res[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input mul_op_e o, input logic [31:0] x, input logic [31:0] y);
    op[k] = o; a[k] = x; b[k] = y; in_valid[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
    a[k] = 32'hDEADBEEF; b[k] = 32'hDEADBEEF;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid[k] && lat < 100);
  endtask

  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
  endtask

  task automatic run(input int k, input mul_op_e o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input string tag);
    int lat;
    issue(k, o, x, y);
    wait_valid(k, lat);
    chk({tag, "_lat"}, lat, (k == 0) ? 33 : 9);
    chk(tag, res[k], exp);
    consume(k);
  endtask

  function automatic logic [31:0] model(input mul_op_e o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] xs, ys, p;
    xs = (o == MULH || o == MULHSU) ? $signed({{34{x[31]}}, x}) : $signed({34'b0, x});
    ys = (o == MULH) ? $signed({{34{y[31]}}, y}) : $signed({34'b0, y});
    p  = xs * ys;
    return (o == MUL) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    logic [31:0] corner [5];
    logic [31:0] x, y;
    mul_op_e     o;
    int          lat;
    logic        seen;
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    flush = '0; in_valid = '0; out_ready = '0;
    op[0] = MUL; op[1] = MUL; a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;

    #2;
    chk("rst_ready", in_ready[0], 1);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_result", res[0], 0);
    step(); step();
    rst = 1'b0;
    step();

    run(0, MUL,    32'd7,        32'd6,        32'h0000002A, "mul_7x6");
    run(0, MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min");
    run(0, MUL,    32'h80000000, 32'h80000000, 32'h00000000, "mul_min_min");
    run(0, MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulh_m1x2");
    run(0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ff");
    run(0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff");
    run(0, MULHU,  32'h00000000, 32'h12345678, 32'h00000000, "mulhu_zero");

    // Backpressure in DONE, then same-edge consume + accept.
    issue(0, MUL, 32'd9, 32'd9);
    wait_valid(0, lat);
    chk("bp_lat", lat, 33);
    op[0] = MUL; a[0] = 32'd3; b[0] = 32'd4; in_valid[0] = 1'b1;
    repeat (5) begin
      step();
      chk("bp_hold_result", res[0], 32'd81);
      chk("bp_hold_valid", out_valid[0], 1);
      chk("bp_hold_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_comb_ready", in_ready[0], 1);
    step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chk("b2b_valid_drop", out_valid[0], 0);
    chk("b2b_busy", in_ready[0], 0);
    wait_valid(0, lat);
    chk("b2b_lat", lat, 33);
    chk("b2b_result", res[0], 32'd12);
    consume(0);

    // Flush mid-CALC at iteration 10.
    issue(0, MUL, 32'd100, 32'd100);
    repeat (9) step();
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("flush_idle", in_ready[0], 1);
    chk("flush_valid", out_valid[0], 0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid[0]) seen = 1'b1;
    end
    chk("flush_no_valid", seen, 0);
    run(0, MUL, 32'd3, 32'd5, 32'd15, "after_flush");

    // Flush together with in_valid suppresses the accept.
    op[0] = MUL; a[0] = 32'd2; b[0] = 32'd2; in_valid[0] = 1'b1; flush[0] = 1'b1;
    step();
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    chk("flush_blocks_accept", in_ready[0], 1);

    // Flush in DONE drops the pending result.
    issue(0, MUL, 32'd5, 32'd5);
    wait_valid(0, lat);
    chk("done_flush_pre", out_valid[0], 1);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("done_flush_valid", out_valid[0], 0);
    chk("done_flush_ready", in_ready[0], 1);

    // Asynchronous reset mid-CALC; result register still holds 25 beforehand.
    issue(0, MUL, 32'd9, 32'd9);
    repeat (5) step();
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", in_ready[0], 1);
    chk("arst_valid", out_valid[0], 0);
    chk("arst_result", res[0], 0);
    step();
    rst = 1'b0;
    step();
    run(0, MUL, 32'd2, 32'd3, 32'd6, "after_rst");

    // K=4 directed corners.
    run(1, MUL,    32'h80000000, 32'h7FFFFFFF, 32'h80000000, "k4_mul_min_max");
    run(1, MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "k4_mulh_m1m1");
    run(1, MULH,   32'h80000000, 32'h7FFFFFFF, 32'hC0000000, "k4_mulh_min_max");
    run(1, MULHU,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, "k4_mulhu_max");
    run(1, MULHSU, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, "k4_mulhsu_min1");
    run(1, MUL,    32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, "k4_mul_1xm1");
    run(1, MULH,   32'h12345678, 32'h00000000, 32'h00000000, "k4_mulh_zero");
    run(1, MUL,    32'h12345678, 32'h00000010, 32'h23456780, "k4_mul_shift");

    // K=4 sweep: every corner pair, then random operands.
    for (int i = 0; i < 300; i++) begin
      if (i < 25) begin
        x = corner[i % 5];
        y = corner[i / 5];
      end else begin
        x = $urandom;
        y = $urandom;
      end
      o = mul_op_e'(i[1:0] ^ 2'(i / 25));
      run(1, o, x, y, model(o, x, y), "k4_sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
